// File: rtl/stopwatch_button_ctrl.sv
// stopwatch_button_ctrl: debounced start/stop and clear buttons driving an IDLE/RUN/PAUSE stopwatch FSM
module stopwatch_button_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic       enable,
  output logic       clr,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  logic [1:0] s1, s2, level, level_d, press;
  logic [CNT_W-1:0] cnt [2];
  state_t cur, nxt;
  logic enable_n, clr_n;
  // bit 0 is start/stop, bit 1 is clear
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      level <= '0;
      level_d <= '0;
      for (int j = 0; j < 2; j++) cnt[j] <= '0;
    end else begin
      s1 <= {btn_clr, btn_ss};
      s2 <= s1;
      level_d <= level;
      for (int j = 0; j < 2; j++) begin
        if (s2[j] == level[j]) cnt[j] <= '0;
        else if (cnt[j] == CNT_W'(DB_CYCLES - 1)) begin
          level[j] <= s2[j];
          cnt[j] <= '0;
        end else cnt[j] <= cnt[j] + CNT_W'(1);
      end
    end
  end
  assign press = level & ~level_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= IDLE;
      enable <= 1'b0;
      clr <= 1'b1;
    end else begin
      cur <= nxt;
      enable <= enable_n;
      clr <= clr_n;
    end
  end
  // clear wins over a simultaneous start/stop press
  always_comb begin
    nxt = press[1] ? IDLE : press[0] ? (cur == RUN ? PAUSE : RUN) : cur;
  end
  always_comb begin
    enable_n = (nxt == RUN);
    clr_n = press[1];
  end
  assign state = cur;
endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// tb_stopwatch_button_ctrl: directed plus random button stimulus checked against an event-level reference model
module tb_stopwatch_button_ctrl;
  localparam int DB = 4;
  logic clk = 1'b0, reset = 1'b1, btn_ss = 1'b0, btn_clr = 1'b0;
  logic enable, clr;
  logic [1:0] state;
  int n_cmp = 0, n_err = 0;
  bit live = 0;
  stopwatch_button_ctrl #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .btn_ss(btn_ss), .btn_clr(btn_clr),
    .enable(enable), .clr(clr), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // Reference: each button's samples reach the debouncer two edges late; a level
  // flips after DB consecutive differing samples, a rising flip is a press that
  // moves the FSM one edge later.
  logic [1:0] m_st;
  logic m_en, m_clr;
  logic m_level [2], sh1 [2], sh2 [2], pend [2], raw [2];
  int streak [2];
  always @(posedge clk) begin
    raw[0] = btn_ss;
    raw[1] = btn_clr;
    if (reset) begin
      m_st = 2'd0;
      m_en = 1'b0;
      m_clr = 1'b1;
      for (int b = 0; b < 2; b++) begin
        m_level[b] = 1'b0; streak[b] = 0; sh1[b] = 1'b0; sh2[b] = 1'b0; pend[b] = 1'b0;
      end
      live = 1;
    end else begin
      if (pend[1]) begin
        m_st = 2'd0;
        m_clr = 1'b1;
      end else begin
        m_clr = 1'b0;
        if (pend[0]) m_st = (m_st == 2'd1) ? 2'd2 : 2'd1;
      end
      m_en = (m_st == 2'd1);
      for (int b = 0; b < 2; b++) begin
        pend[b] = 1'b0;
        if (sh2[b] != m_level[b]) begin
          streak[b]++;
          if (streak[b] == DB) begin
            m_level[b] = sh2[b];
            streak[b] = 0;
            pend[b] = m_level[b];
          end
        end else streak[b] = 0;
        sh2[b] = sh1[b];
        sh1[b] = raw[b];
      end
    end
    #1;
    if (live) begin
      chk("state", state, m_st);
      chk("enable", {1'b0, enable}, {1'b0, m_en});
      chk("clr", {1'b0, clr}, {1'b0, m_clr});
    end
  end
  task automatic drive(input logic r, input logic ss, input logic cl, input int n);
    reset = r;
    btn_ss = ss;
    btn_clr = cl;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    drive(1, 0, 0, 3);
    drive(0, 0, 0, 4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 10);
      drive(0, 0, 0, 3);
    end
    drive(0, 1, 0, 2); drive(0, 0, 0, 1); drive(0, 1, 0, 3); drive(0, 0, 0, 1);
    drive(0, 0, 0, 20);
    drive(0, 1, 0, 8); drive(0, 0, 0, 4);
    drive(0, 0, 1, 15); drive(0, 0, 0, 5);
    drive(0, 1, 0, 8); drive(0, 0, 0, 3);
    drive(0, 1, 0, 8); drive(0, 0, 0, 3);
    drive(0, 1, 1, 8); drive(0, 0, 0, 5);
    drive(0, 1, 0, 3); drive(1, 1, 0, 1); drive(0, 1, 0, 10); drive(0, 0, 0, 4);
    drive(0, 3'(0), 1, 3); drive(0, 1, 0, 2); drive(0, 1, 1, 8); drive(0, 0, 0, 4);
    for (int i = 0; i < 500; i++)
      drive(logic'($urandom_range(0, 59) == 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) == 0), int'($urandom_range(1, 9)));
    drive(0, 0, 0, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
